hdmi_pkt_sched: RTL and testbench
=================================

# hdmi_pkt_sched

Data-island packet scheduler for the HDMI transmit path. Arbitrates among NS packet sources (ACR, audio sample, infoframe, GCP, …) and feeds one 31-byte packet at a time (3 header bytes + 28 body bytes) to the downstream BCH encoder, which appends all parity. Packets go out only inside blanking windows announced by the video timing generator, and never beyond the slot budget of that window. Malformed source packets are forced to exactly 31 bytes.

## Interface

- NS, 4: number of packet sources (2..8); source 0 is highest priority.
- MAXSLOTS, 18: maximum packets per data-island window.

- i_clk  in  1  pixel-rate clock
- i_reset  in  1  reset; synchronous, active-high; clock i_clk
- i_win_start  in  1  one-cycle pulse: blanking window opens
- i_win_slots  in  5  packets allowed in this window; sampled with i_win_start
- S_VALID  in  NS  per-source byte valid
- S_READY  out  NS  per-source byte accept
- S_DATA  in  8*NS  per-source byte; source k occupies [8k+7:8k]
- S_LAST  in  NS  per-source last byte of packet
- M_VALID  out  1  byte valid to encoder
- M_READY  in  1  encoder accept
- M_DATA  out  8  packet byte
- M_LAST  out  1  byte 30 (final byte) of packet
- o_island  out  1  island active, from first grant until final M_LAST handshake
- o_err  out  NS  sticky length-error flag per source; cleared only by reset

## Operation

- States: IDLE, ARB, XFER, PAD, DRAIN.
- IDLE: slots_left=0, S_READY=0, M_VALID=0.
  - On i_win_start, slots_left <= min(i_win_slots, MAXSLOTS); go to ARB.
  - i_win_start outside IDLE is ignored.
- ARB (one cycle):
  - slots_left==0 → IDLE; o_island drops.
  - No S_VALID set → IDLE. The rest of the window is forfeited; no null packets are sent.
  - Otherwise register grant g: source 0 if S_VALID[0]; else round-robin over 1..NS-1, starting after the last granted nonzero source (pointer reset value: NS-1, so source 1 wins first); bcnt<=0; go to XFER.
- XFER: combinational pass-through of source g.
  - M_VALID=S_VALID[g], M_DATA=S_DATA[8g+:8], S_READY[g]=M_READY; other S_READY=0.
  - M_LAST=(bcnt==30). bcnt increments on each M handshake.
  - Handshake with S_LAST[g] and bcnt<30 → PAD.
  - Handshake at bcnt==30 without S_LAST[g] → DRAIN; set o_err[g].
  - Handshake at bcnt==30 with S_LAST[g] → packet done.
- PAD: S_READY=0; M_VALID=1, M_DATA=0 until the bcnt==30 handshake; set o_err[g]; packet done.
- DRAIN: M_VALID=0; S_READY[g]=1; discard bytes through the S_LAST[g] handshake, then go to ARB. The slot was already decremented.
- Packet done: slots_left--, update the round-robin pointer (only if g≠0), go to ARB.
- bcnt is 5 bits and never exceeds 30. slots_left is 5 bits and saturates at 0.

## Timing

- Reset values: S_READY=0, M_VALID=0, M_DATA=0, M_LAST=0, o_island=0, o_err=0; state IDLE, slots_left=0.
- Reset mid-packet aborts immediately. The encoder sees M_VALID drop with no M_LAST; the encoder is reset together with this block.
- i_win_start at cycle 0 → ARB at cycle 1 → first M_VALID possible at cycle 2.
- Minimum gap between packets: one ARB bubble. Back-to-back packets at full rate therefore take 32 cycles each.
- o_island rises with the first XFER cycle and falls the cycle after the ARB that exits to IDLE.
- M_DATA/M_VALID/M_LAST are combinational from the source in XFER (no added latency). Grant and state are registered.
- The source holding a grant keeps it until packet done; priority is evaluated only in ARB.
- M_READY stalls: all state and counters hold. The source sees S_READY low.

## Test plan

- Window slots=3; sources 1,2,3 always valid with well-formed 31-byte packets → grants 1,2,3 in order; 93 M beats; three M_LAST; o_island low again 1 cycle after the final ARB.
- Sources 0 and 2 always valid, slots=4 → grants 0,0,0,0. Then with source 0 idle, a new window of 2 slots → grants go to 2, then 3 if valid, else 2.
- Source 1 asserts S_LAST on byte 10 → bytes 11..30 output as 0x00, M_LAST on byte 30, o_err[1]=1.
- Source 2 sends 40 bytes → M_LAST on byte 30; 9 extra bytes accepted and discarded with M_VALID=0; o_err[2]=1; next grant follows.
- M_READY toggled 50% randomly and i_win_slots=25 → no byte lost or duplicated; exactly 18 packets sent; second i_win_start pulse mid-island ignored.
- i_reset asserted at bcnt=12 → next cycle all outputs at reset values. A following window with slots=1 sends one complete packet from the start.

Source files
------------

// File: rtl/hdmi_pkt_sched_if.sv
// Byte-stream bundle between the packet sources, the data-island scheduler and the BCH encoder.
// master is the scheduler side; slave is the sources/encoder side.
interface hdmi_pkt_sched_if #(
    parameter int unsigned NS = 4
) ();
    logic [NS-1:0]   S_VALID;
    logic [NS-1:0]   S_READY;
    logic [8*NS-1:0] S_DATA;
    logic [NS-1:0]   S_LAST;
    logic            M_VALID;
    logic            M_READY;
    logic [7:0]      M_DATA;
    logic            M_LAST;

    modport master (
        input  S_VALID, S_DATA, S_LAST, M_READY,
        output S_READY, M_VALID, M_DATA, M_LAST
    );

    modport slave (
        output S_VALID, S_DATA, S_LAST, M_READY,
        input  S_READY, M_VALID, M_DATA, M_LAST
    );
endinterface

// File: rtl/hdmi_pkt_sched.sv
// HDMI data-island packet scheduler: arbitrates NS sources into 31-byte packets for the BCH
// encoder, bounded by the slot budget of each blanking window; malformed packets padded/drained.
module hdmi_pkt_sched #(
    parameter int unsigned NS       = 4,
    parameter int unsigned MAXSLOTS = 18
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_win_start,
    input  logic [4:0]          i_win_slots,
    hdmi_pkt_sched_if.master    bus,
    output logic                o_island,
    output logic [NS-1:0]       o_err
);
    localparam int unsigned GW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [4:0] LastByte = 5'd30;

    typedef enum logic [2:0] {StIdle, StArb, StXfer, StPad, StDrain} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [4:0]      bcnt_q, bcnt_d;
    logic [4:0]      slots_q, slots_d;
    logic            island_q, island_d;
    logic [NS-1:0]   err_q, err_d;

    logic [7:0]      src_byte [NS];
    logic            src_valid, src_last;
    logic            arb_found;
    logic [GW-1:0]   arb_idx;
    logic [NS-1:0]   s_ready;
    logic            m_valid, m_last;
    logic [7:0]      m_data;

    always_comb begin
        for (int unsigned k = 0; k < NS; k++) begin
            src_byte[k] = bus.S_DATA[8*k +: 8];
        end
    end

    assign src_valid = bus.S_VALID[grant_q];
    assign src_last  = bus.S_LAST[grant_q];

    // Source 0 is absolute priority; 1..NS-1 rotate starting just after rr_q.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        if (bus.S_VALID[0]) begin
            arb_found = 1'b1;
        end else begin
            for (int unsigned k = 1; k < NS; k++) begin
                cand = ((32'(rr_q) + k - 1) % (NS - 1)) + 1;
                if (!arb_found && bus.S_VALID[GW'(cand)]) begin
                    arb_found = 1'b1;
                    arb_idx   = GW'(cand);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        bcnt_d   = bcnt_q;
        slots_d  = slots_q;
        island_d = island_q;
        err_d    = err_q;
        s_ready  = '0;
        m_valid  = 1'b0;
        m_data   = 8'h00;
        m_last   = 1'b0;

        unique case (state_q)
            StIdle: begin
                slots_d = 5'd0;
                if (i_win_start) begin
                    slots_d = (i_win_slots > 5'(MAXSLOTS)) ? 5'(MAXSLOTS) : i_win_slots;
                    state_d = StArb;
                end
            end
            StArb: begin
                if (slots_q == 5'd0 || !arb_found) begin
                    slots_d  = 5'd0;
                    island_d = 1'b0;
                    state_d  = StIdle;
                end else begin
                    grant_d  = arb_idx;
                    bcnt_d   = 5'd0;
                    island_d = 1'b1;
                    state_d  = StXfer;
                end
            end
            StXfer: begin
                m_valid          = src_valid;
                m_data           = src_byte[grant_q];
                m_last           = (bcnt_q == LastByte);
                s_ready[grant_q] = bus.M_READY;
                if (src_valid && bus.M_READY) begin
                    if (bcnt_q == LastByte) begin
                        // Overlong packets finish on the wire here; the tail is drained silently.
                        slots_d = (slots_q == 5'd0) ? 5'd0 : slots_q - 5'd1;
                        if (grant_q != '0) rr_d = grant_q;
                        if (src_last) begin
                            state_d = StArb;
                        end else begin
                            err_d[grant_q] = 1'b1;
                            state_d        = StDrain;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                        if (src_last) begin
                            err_d[grant_q] = 1'b1;
                            state_d        = StPad;
                        end
                    end
                end
            end
            StPad: begin
                m_valid = 1'b1;
                m_last  = (bcnt_q == LastByte);
                if (bus.M_READY) begin
                    if (bcnt_q == LastByte) begin
                        slots_d = (slots_q == 5'd0) ? 5'd0 : slots_q - 5'd1;
                        if (grant_q != '0) rr_d = grant_q;
                        state_d = StArb;
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                    end
                end
            end
            StDrain: begin
                s_ready[grant_q] = 1'b1;
                if (src_valid && src_last) state_d = StArb;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_q     <= GW'(NS - 1);
            bcnt_q   <= 5'd0;
            slots_q  <= 5'd0;
            island_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            bcnt_q   <= bcnt_d;
            slots_q  <= slots_d;
            island_q <= island_d;
            err_q    <= err_d;
        end
    end

    assign bus.S_READY = s_ready;
    assign bus.M_VALID = m_valid;
    assign bus.M_DATA  = m_data;
    assign bus.M_LAST  = m_last;
    assign o_island    = island_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_hdmi_pkt_sched.sv
// Directed bench for hdmi_pkt_sched: table of windows with expected grant order and error flags,
// plus hand-written sequences for random encoder stalls and mid-packet reset.
module tb_hdmi_pkt_sched;
    localparam int NS = 4;

    logic       clk;
    logic       rst;
    logic       win_start;
    logic [4:0] win_slots;
    logic       island;
    logic [3:0] err;
    logic       m_ready;
    logic       rnd;

    hdmi_pkt_sched_if #(.NS(NS)) bus ();

    hdmi_pkt_sched #(.NS(NS), .MAXSLOTS(18)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_win_start (win_start),
        .i_win_slots (win_slots),
        .bus         (bus),
        .o_island    (island),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Source model and scoreboard state
    logic [3:0] en_v;
    int lens [NS];
    int idx [NS];
    int pkt [NS];
    int exp_pkt [NS];
    int exp_q [$];
    int mb;
    int pkts;

    logic       s_mvalid, s_mlast, s_island;
    logic [7:0] s_mdata;
    logic [3:0] s_sready, s_err;

    typedef struct {
        logic [4:0]  slots;
        logic [3:0]  en;
        int          len [NS];
        int          ngr;
        logic [71:0] gr;   // grant k in nibble k
        logic [3:0]  err;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [7:0] data_of(input int k, input int p, input int i);
        logic [4:0] lo;
        logic [1:0] kk;
        lo = 5'(i + p * 3);
        kk = 2'(k);
        return {1'b1, kk, lo};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NS; k++) begin
            bus.S_VALID[k]       = en_v[k];
            bus.S_DATA[8*k +: 8] = data_of(k, pkt[k], idx[k]);
            bus.S_LAST[k]        = (idx[k] == lens[k] - 1);
        end
        bus.M_READY = m_ready;
    endtask

    task automatic sample();
        int src;
        logic [7:0] ed;
        s_mvalid = bus.M_VALID;
        s_mdata  = bus.M_DATA;
        s_mlast  = bus.M_LAST;
        s_sready = bus.S_READY;
        s_island = island;
        s_err    = err;
        if (bus.M_VALID && bus.M_READY) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'(bus.M_DATA), 32'hffff_ffff);
            end else begin
                src = exp_q[0];
                ed  = (mb < lens[src]) ? data_of(src, exp_pkt[src], mb) : 8'h00;
                chk($sformatf("data s%0d b%0d", src, mb), 32'(bus.M_DATA), 32'(ed));
                chk($sformatf("last s%0d b%0d", src, mb), 32'(bus.M_LAST), 32'(mb == 30));
                if (mb == 30) begin
                    void'(exp_q.pop_front());
                    exp_pkt[src]++;
                    mb = 0;
                    pkts++;
                end else begin
                    mb++;
                end
            end
        end
        for (int k = 0; k < NS; k++) begin
            if (bus.S_VALID[k] && bus.S_READY[k]) begin
                if (idx[k] >= 31) chk("drain_mvalid", 32'(bus.M_VALID), 32'd0);
                if (idx[k] == lens[k] - 1) begin
                    idx[k] = 0;
                    pkt[k]++;
                end else begin
                    idx[k]++;
                end
            end
        end
    endtask

    task automatic cycle();
        if (rnd) m_ready = 1'($urandom_range(0, 1));
        drive();
        #3;
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input logic [4:0] slots, input int budget, input int inject,
                              input int exp_pkts, input logic [3:0] exp_err, input string tag);
        logic seen, done;
        seen      = 1'b0;
        done      = 1'b0;
        pkts      = 0;
        win_start = 1'b1;
        win_slots = slots;
        cycle();
        win_start = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            if (n == inject) begin
                win_start = 1'b1;
                win_slots = 5'd5;
            end else begin
                win_start = 1'b0;
            end
            cycle();
            if (s_island) seen = 1'b1;
            else if (seen || n >= 6) done = 1'b1;
        end
        win_start = 1'b0;
        chk({tag, " finished"}, 32'(done), 32'd1);
        chk({tag, " pkts"}, 32'(pkts), 32'(exp_pkts));
        chk({tag, " grants_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, " err"}, 32'(s_err), 32'(exp_err));
        chk({tag, " mvalid_idle"}, 32'(s_mvalid), 32'd0);
        exp_q.delete();
        mb = 0;
    endtask

    task automatic set_vec(input int i, input logic [4:0] slots, input logic [3:0] en,
                           input int l1, input int l2, input int ngr, input logic [71:0] gr,
                           input logic [3:0] e);
        vecs[i].slots  = slots;
        vecs[i].en     = en;
        vecs[i].len[0] = 31;
        vecs[i].len[1] = l1;
        vecs[i].len[2] = l2;
        vecs[i].len[3] = 31;
        vecs[i].ngr    = ngr;
        vecs[i].gr     = gr;
        vecs[i].err    = e;
    endtask

    initial begin
        logic [71:0] g;
        set_vec(0, 5'd3,  4'b1110, 31, 31, 3,  72'h321, 4'b0000);
        set_vec(1, 5'd4,  4'b0101, 31, 31, 4,  72'h0,   4'b0000);
        set_vec(2, 5'd2,  4'b1100, 31, 31, 2,  72'h32,  4'b0000);
        set_vec(3, 5'd2,  4'b0100, 31, 31, 2,  72'h22,  4'b0000);
        set_vec(4, 5'd1,  4'b0010, 11, 31, 1,  72'h1,   4'b0010);
        set_vec(5, 5'd2,  4'b0100, 11, 40, 2,  72'h22,  4'b0110);
        set_vec(6, 5'd0,  4'b1111, 31, 31, 0,  72'h0,   4'b0110);
        set_vec(7, 5'd25, 4'b1111, 31, 31, 18, 72'h0,   4'b0110);
        set_vec(8, 5'd5,  4'b0000, 31, 31, 0,  72'h0,   4'b0110);

        rnd = 1'b0; m_ready = 1'b1; win_start = 1'b0; win_slots = 5'd0; en_v = '0; mb = 0;
        pkts = 0;
        for (int k = 0; k < NS; k++) begin
            lens[k] = 31; idx[k] = 0; pkt[k] = 0; exp_pkt[k] = 0;
        end
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("reset mvalid", 32'(s_mvalid), 32'd0);
        chk("reset sready", 32'(s_sready), 32'd0);
        chk("reset island", 32'(s_island), 32'd0);
        chk("reset err", 32'(s_err), 32'd0);

        for (int i = 0; i < 9; i++) begin
            en_v = vecs[i].en;
            for (int k = 0; k < NS; k++) lens[k] = vecs[i].len[k];
            g = vecs[i].gr;
            for (int j = 0; j < vecs[i].ngr; j++) exp_q.push_back(int'(g[4*j +: 4]));
            run_window(vecs[i].slots, 2000, -1, vecs[i].ngr, vecs[i].err,
                       $sformatf("vec%0d", i));
        end

        // Random encoder stalls, budget capped at 18, second window pulse mid-island
        rst = 1'b1; en_v = '0;
        cycle();
        rst = 1'b0;
        en_v = 4'b1110;
        for (int k = 0; k < NS; k++) lens[k] = 31;
        for (int j = 0; j < 18; j++) exp_q.push_back((j % 3) + 1);
        rnd = 1'b1;
        run_window(5'd25, 4000, 100, 18, 4'b0000, "stall");
        rnd = 1'b0; m_ready = 1'b1;

        // Reset at bcnt=12, then a one-slot window restarts cleanly
        en_v = 4'b0010;
        exp_q.push_back(1);
        win_start = 1'b1; win_slots = 5'd1;
        cycle();
        win_start = 1'b0;
        cycle();
        chk("arb bubble mvalid", 32'(s_mvalid), 32'd0);
        chk("arb island", 32'(s_island), 32'd0);
        cycle();
        chk("first beat mvalid", 32'(s_mvalid), 32'd1);
        chk("first beat island", 32'(s_island), 32'd1);
        for (int n = 0; n < 40 && mb < 12; n++) cycle();
        chk("reached bcnt12", 32'(mb), 32'd12);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_q.delete(); mb = 0; idx[1] = 0;
        cycle();
        chk("rst mvalid", 32'(s_mvalid), 32'd0);
        chk("rst mlast", 32'(s_mlast), 32'd0);
        chk("rst mdata", 32'(s_mdata), 32'd0);
        chk("rst sready", 32'(s_sready), 32'd0);
        chk("rst island", 32'(s_island), 32'd0);
        exp_q.push_back(1);
        run_window(5'd1, 200, -1, 1, 4'b0000, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
